// File: rtl/inst_loader.sv
// inst_loader: assembles a byte stream into 32-bit instruction words, writes
// them into instruction memory while the core is stalled, then hands the
// memory address port to the core and releases the stall until it halts.
module inst_loader #(
    parameter int unsigned WORD  = 32,
    parameter int unsigned ADDR  = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [ADDR-1:0] len_i,
    input  logic [7:0]      byte_i,
    input  logic            byte_valid_i,
    output logic            byte_ready_o,
    input  logic [ADDR-1:0] core_addr_i,
    input  logic            hlt_i,
    output logic [ADDR-1:0] mem_addr_o,
    output logic [WORD-1:0] mem_data_o,
    output logic            mem_write_o,
    output logic            stall_o,
    output logic            done_o,
    output logic            err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RECV   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [ADDR-1:0] DEPTH_A = ADDR'(DEPTH);

    logic [2:0]      state_q,    state_d;
    logic [ADDR-1:0] len_q,      len_d;
    logic [ADDR-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [WORD-1:0] shift_q,    shift_d;
    logic [ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [WORD-1:0] mem_data_q, mem_data_d;
    logic            mem_write_q, mem_write_d;
    logic            byte_ready_q, byte_ready_d;
    logic            stall_q,    stall_d;
    logic            done_q,     done_d;
    logic            err_q,      err_d;

    logic            byte_acc;
    logic [ADDR-1:0] word_inc;
    logic [WORD-1:0] shift_next;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        err_d      = err_q;

        byte_acc   = byte_valid_i && byte_ready_q;
        word_inc   = word_cnt_q + ADDR'(1);
        shift_next = {shift_q[WORD-9:0], byte_i};

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = S_RUN;
                    end else if (len_i > DEPTH_A) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = len_i;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        shift_d    = '0;
                        err_d      = 1'b0;
                        state_d    = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (byte_acc) begin
                    shift_d    = shift_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte completes the word: stage the write
                    if (byte_cnt_q == 2'd3) begin
                        mem_addr_d = word_cnt_q;
                        mem_data_d = shift_next;
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_inc;
                state_d    = (word_inc == len_q) ? S_RUN : S_RECV;
            end
            S_RUN: begin
                // Track the core address so HALTED holds the last one seen
                mem_addr_d = core_addr_i;
                if (hlt_i) begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stall_d      = (state_d != S_RUN);
        done_d       = (state_d == S_RUN) || (state_d == S_HALTED);
        byte_ready_d = (state_d == S_RECV);
        mem_write_d  = (state_d == S_WRITE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_write_q  <= 1'b0;
            byte_ready_q <= 1'b0;
            stall_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_write_q  <= mem_write_d;
            byte_ready_q <= byte_ready_d;
            stall_q      <= stall_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // While running, the core owns the memory address port directly
    assign mem_addr_o   = (state_q == S_RUN) ? core_addr_i : mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_write_o  = mem_write_q;
    assign byte_ready_o = byte_ready_q;
    assign stall_o      = stall_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Front-end stage between an external byte stream and `mem_instruction`.
- While the core is held stalled, it assembles incoming bytes into 32-bit instruction words and writes them to consecutive instruction-memory addresses.
- After the programmed word count is loaded, it hands the instruction-memory address port to the core and releases the stall.
- It watches `hlt_o` and stalls the core again on halt.

Parameters:
- WORD, 32, instruction word width (fixed at 4 bytes).
- ADDR, 32, instruction-memory address width.
- DEPTH, 256, instruction-memory depth in words; maximum legal load length.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  start a load; sampled only in IDLE or HALTED.
- len_i  input  ADDR  number of words to load; sampled with start_i.
- byte_i  input  8  stream byte, MSB-first within each word.
- byte_valid_i  input  1  byte_i valid.
- byte_ready_o  output  1  loader can accept a byte.
- core_addr_i  input  ADDR  core instruction address (`inst_addr_o`).
- hlt_i  input  1  core halt indication.
- mem_addr_o  output  ADDR  address to `mem_instruction` A.
- mem_data_o  output  WORD  data to `mem_instruction` D.
- mem_write_o  output  1  write to `mem_instruction` W.
- stall_o  output  1  core stall (drives `stall_i` of top).
- done_o  output  1  load complete, core running or halted.
- err_o  output  1  sticky illegal-length flag.

Behaviour:
- Reset values:
  - State IDLE.
  - stall_o=1, byte_ready_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, done_o=0, err_o=0.
  - Word counter, byte counter and shift register all 0.
- States and transitions:
  - IDLE: stall_o=1.
    - start_i & len_i==0: go to RUN.
    - start_i & len_i>DEPTH: err_o<=1, stay IDLE.
    - start_i & 1<=len_i<=DEPTH: latch len, clear counters, err_o<=0, go to RECV.
  - RECV: byte_ready_o=1.
    - A byte is accepted when byte_valid_i & byte_ready_o at posedge: shift={shift[23:0],byte_i}, byte_cnt++.
    - On the 4th accepted byte (byte_cnt 3->0), go to WRITE next cycle.
  - WRITE: exactly one cycle.
    - byte_ready_o=0, mem_write_o=1, mem_addr_o=word_cnt, mem_data_o=shift.
    - Next: word_cnt++.
    - If word_cnt+1==len, go to RUN; else go to RECV.
  - RUN: stall_o=0, done_o=1, mem_write_o=0, mem_addr_o=core_addr_i (combinational pass-through), byte_ready_o=0.
    - hlt_i sampled 1: go to HALTED.
  - HALTED: stall_o=1, done_o=1, mem_addr_o held at last core address, mem_write_o=0.
    - start_i: same handling as in IDLE (reload or error).
- Latency:
  - First write occurs 1 cycle after the 4th byte of word 0.
  - Stall deasserts 1 cycle after the final WRITE cycle.
  - Minimum load time is 5*len cycles with continuous valid.
- Output timing:
  - mem_write_o, mem_addr_o and mem_data_o are registered in every state except RUN, where mem_addr_o follows core_addr_i.
  - stall_o is registered.
- Stream handling:
  - Bytes presented while byte_ready_o=0 are not consumed; the source must hold them.
  - Gaps in byte_valid_i are allowed anywhere within a word; the partial word is retained.
- Boundary conditions:
  - start_i asserted in RECV, WRITE or RUN is ignored.
  - len_i==DEPTH is legal: last write goes to DEPTH-1; no wrap.
  - hlt_i outside RUN is ignored.
  - Reset mid-load: immediate return to IDLE, outputs at reset values. Already-written memory words are not cleared.
- Widths: counters are ADDR bits wide. The len_i comparison is unsigned.

Test Plan:
- Load len=2, bytes 0x12,0x34,0x56,0x78,0xDE,0xAD,0xBE,0xEF continuous.
  - Writes (addr0, 0x12345678), then (addr1, 0xDEADBEEF), one mem_write_o pulse each.
  - stall_o falls 1 cycle after the 2nd write; done_o=1.
- Same load with byte_valid_i toggling every other cycle.
  - Identical writes and data; byte_ready_o low during each WRITE cycle; no byte lost or duplicated.
- start_i with len_i=DEPTH+1 (257).
  - err_o=1, state IDLE, no writes, stall_o=1.
- Subsequent start_i with len_i=1.
  - err_o clears; one write; RUN.
- In RUN, drive core_addr_i=0x10, then pulse hlt_i.
  - mem_addr_o=0x10 combinationally.
  - Next cycle stall_o=1, done_o=1, mem_write_o=0.
- After halt, start_i with len=1, bytes 0x00000001.
  - Reload writes addr0=0x00000001; returns to RUN.
- Assert reset after 2 bytes of word 1 of a len=3 load.
  - All outputs return to reset values asynchronously; word 0 remains in memory.
- start_i with len_i=0.
  - Direct RUN next cycle; no writes.
